// File: rtl/ysyx_22040383_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ysyx_22040383_mem_stage                                        |
// | Brief   : Memory stage with a req/gnt/rvalid data port and load extend.  |
// |           Optional macro YSYX_22040383_MISALIGN_CHK_EN traps misaligned. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ysyx_22040383_mem_stage (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        mempr_mem_valid,
   input  logic [63:0] mempr_mem_now_pc,
   input  logic [31:0] mempr_mem_instruction,
   input  logic [63:0] mempr_mem_alu_result,
   input  logic [63:0] mempr_mem_store_data,
   input  logic        mempr_mem_is_load,
   input  logic        mempr_mem_is_store,
   input  logic        mempr_mem_unsigned,
   input  logic [1:0]  mempr_mem_size,
   input  logic [4:0]  mempr_mem_rd,
   input  logic        mempr_mem_is_write_rf,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wmask,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [63:0] dmem_rdata,
   output logic [63:0] mem_wbpr_write_back_data,
   output logic [4:0]  mem_wbpr_write_back_addr,
   output logic [63:0] mempr_wbpr_now_pc,
   output logic [31:0] mempr_wbpr_instruction,
   output logic        mempr_wbpr_is_write_rf,
   output logic        mempr_wbpr_stall,
   output logic        mem_stall,
   output logic        mem_misalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_rdata;
   logic        w_req;
   logic        w_stall;
   logic        w_is_ld;
   logic        w_is_st;
   logic        w_is_mem;
   logic        w_misalign;
   logic [2:0]  w_off;
   logic [7:0]  w_size_mask;
   logic [63:0] w_shifted;
   logic [63:0] w_load_val;
   logic        w_sext;

   // A simultaneous load+store request is handled as a load.
   assign w_is_ld  = mempr_mem_is_load;
   assign w_is_st  = mempr_mem_is_store & ~mempr_mem_is_load;
   assign w_is_mem = mempr_mem_valid & (mempr_mem_is_load | mempr_mem_is_store);
   assign w_off    = mempr_mem_alu_result[2:0];

`ifdef YSYX_22040383_MISALIGN_CHK_EN
   logic [2:0] w_align_bits;

   always_comb begin
      w_align_bits = 3'b000;
      case (mempr_mem_size)
         2'b00:   w_align_bits = 3'b000;
         2'b01:   w_align_bits = 3'b001;
         2'b10:   w_align_bits = 3'b011;
         default: w_align_bits = 3'b111;
      endcase
   end

   assign w_misalign = w_is_mem & (|(w_off & w_align_bits));
`else
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         r_state <= S_IDLE;
         r_rdata <= 64'd0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_WAIT && dmem_rvalid) begin
            r_rdata <= dmem_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_is_mem && !w_misalign) begin
               w_stall     = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            if (dmem_gnt) begin
               w_state_nxt = w_is_ld ? S_WAIT : S_DONE;
            end
         end
         S_WAIT: begin
            w_stall = 1'b1;
            if (dmem_rvalid) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_size_mask = 8'h01;
      case (mempr_mem_size)
         2'b00:   w_size_mask = 8'h01;
         2'b01:   w_size_mask = 8'h03;
         2'b10:   w_size_mask = 8'h0F;
         default: w_size_mask = 8'hFF;
      endcase
   end

   // Lanes shifted past byte 7 fall off the top of the 64-bit word.
   assign dmem_addr  = {mempr_mem_alu_result[63:3], 3'b000};
   assign dmem_wdata = mempr_mem_store_data << {w_off, 3'b000};
   assign dmem_wmask = w_size_mask << w_off;
   assign dmem_req   = sys_rst & w_req;
   assign dmem_we    = sys_rst & w_req & w_is_st;

   assign w_shifted = r_rdata >> {w_off, 3'b000};
   assign w_sext    = ~mempr_mem_unsigned;

   always_comb begin
      w_load_val = w_shifted;
      case (mempr_mem_size)
         2'b00:   w_load_val = {{56{w_sext & w_shifted[7]}},  w_shifted[7:0]};
         2'b01:   w_load_val = {{48{w_sext & w_shifted[15]}}, w_shifted[15:0]};
         2'b10:   w_load_val = {{32{w_sext & w_shifted[31]}}, w_shifted[31:0]};
         default: w_load_val = w_shifted;
      endcase
   end

   assign mem_stall    = sys_rst & w_stall;
   assign mem_misalign = sys_rst & w_misalign;

   assign mempr_wbpr_stall       = ~sys_rst | ~mempr_mem_valid | w_stall | w_misalign;
   assign mempr_wbpr_is_write_rf = ~mempr_wbpr_stall & mempr_mem_is_write_rf & ~w_is_st;

   assign mem_wbpr_write_back_data = (r_state == S_DONE && w_is_ld) ? w_load_val
                                                                     : mempr_mem_alu_result;
   assign mem_wbpr_write_back_addr = mempr_mem_rd;
   assign mempr_wbpr_now_pc        = mempr_mem_now_pc;
   assign mempr_wbpr_instruction   = mempr_mem_instruction;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040383_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ysyx_22040383_mem_stage                                     |
// | Brief   : Randomised and directed bench against a byte-lane model.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ysyx_22040383_mem_stage;

   logic        sys_clk;
   logic        sys_rst;
   logic        mempr_mem_valid;
   logic [63:0] mempr_mem_now_pc;
   logic [31:0] mempr_mem_instruction;
   logic [63:0] mempr_mem_alu_result;
   logic [63:0] mempr_mem_store_data;
   logic        mempr_mem_is_load;
   logic        mempr_mem_is_store;
   logic        mempr_mem_unsigned;
   logic [1:0]  mempr_mem_size;
   logic [4:0]  mempr_mem_rd;
   logic        mempr_mem_is_write_rf;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic [63:0] mem_wbpr_write_back_data;
   logic [4:0]  mem_wbpr_write_back_addr;
   logic [63:0] mempr_wbpr_now_pc;
   logic [31:0] mempr_wbpr_instruction;
   logic        mempr_wbpr_is_write_rf;
   logic        mempr_wbpr_stall;
   logic        mem_stall;
   logic        mem_misalign;

   int n_vec;
   int n_err;

   typedef struct packed {
      logic [31:0] stalls;
      logic [31:0] req_total;
      logic        timeout;
      logic [63:0] wb_data;
      logic [4:0]  wb_addr;
      logic        wb_wrf;
      logic        wb_stall;
      logic        misal;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        granted;
      logic [63:0] g_addr;
      logic [63:0] g_wdata;
      logic [7:0]  g_wmask;
      logic        g_we;
   } obs_t;

   ysyx_22040383_mem_stage dut (
      .sys_clk                  (sys_clk),
      .sys_rst                  (sys_rst),
      .mempr_mem_valid          (mempr_mem_valid),
      .mempr_mem_now_pc         (mempr_mem_now_pc),
      .mempr_mem_instruction    (mempr_mem_instruction),
      .mempr_mem_alu_result     (mempr_mem_alu_result),
      .mempr_mem_store_data     (mempr_mem_store_data),
      .mempr_mem_is_load        (mempr_mem_is_load),
      .mempr_mem_is_store       (mempr_mem_is_store),
      .mempr_mem_unsigned       (mempr_mem_unsigned),
      .mempr_mem_size           (mempr_mem_size),
      .mempr_mem_rd             (mempr_mem_rd),
      .mempr_mem_is_write_rf    (mempr_mem_is_write_rf),
      .dmem_req                 (dmem_req),
      .dmem_we                  (dmem_we),
      .dmem_addr                (dmem_addr),
      .dmem_wdata               (dmem_wdata),
      .dmem_wmask               (dmem_wmask),
      .dmem_gnt                 (dmem_gnt),
      .dmem_rvalid              (dmem_rvalid),
      .dmem_rdata               (dmem_rdata),
      .mem_wbpr_write_back_data (mem_wbpr_write_back_data),
      .mem_wbpr_write_back_addr (mem_wbpr_write_back_addr),
      .mempr_wbpr_now_pc        (mempr_wbpr_now_pc),
      .mempr_wbpr_instruction   (mempr_wbpr_instruction),
      .mempr_wbpr_is_write_rf   (mempr_wbpr_is_write_rf),
      .mempr_wbpr_stall         (mempr_wbpr_stall),
      .mem_stall                (mem_stall),
      .mem_misalign             (mem_misalign)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Reference model: pick individual byte lanes, no shifter.
   function automatic logic [63:0] exp_load(input logic [63:0] rd, input int off,
                                            input int nb, input logic uns);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < nb; i++)
         if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!uns && v[8*nb-1])
         for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [7:0] exp_mask(input int off, input int nb);
      logic [7:0] m;
      m = 8'd0;
      for (int i = 0; i < nb; i++)
         if (off + i < 8) m[off+i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] sd, input int off);
      logic [63:0] w;
      w = 64'd0;
      for (int j = 0; j < 8; j++)
         if (off + j < 8) w[8*(off+j) +: 8] = sd[8*j +: 8];
      return w;
   endfunction

   function automatic logic exp_misal(input logic mem, input int off, input int nb);
`ifdef YSYX_22040383_MISALIGN_CHK_EN
      return mem && ((off % nb) != 0);
`else
      return 1'b0;
`endif
   endfunction

   // Drives one instruction and plays the memory side; returns what was seen.
   task automatic do_op(input logic ld, input logic st, input logic uns, input logic [1:0] sz,
                        input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] rdv,
                        input int gw, input int rw, input logic wrf, input logic [4:0] rd,
                        input logic noise, output obs_t o);
      int  req_seen;
      int  wait_seen;
      int  phase;
      logic done;
      logic gnt_now;
      o = '0;
      mempr_mem_valid       = 1'b1;
      mempr_mem_now_pc      = {$urandom, $urandom};
      mempr_mem_instruction = $urandom;
      mempr_mem_alu_result  = alu;
      mempr_mem_store_data  = sd;
      mempr_mem_is_load     = ld;
      mempr_mem_is_store    = st;
      mempr_mem_unsigned    = uns;
      mempr_mem_size        = sz;
      mempr_mem_rd          = rd;
      mempr_mem_is_write_rf = wrf;
      req_seen  = 0;
      wait_seen = 0;
      phase     = 0;
      done      = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         dmem_gnt    = 1'b0;
         dmem_rvalid = 1'b0;
         dmem_rdata  = {$urandom, $urandom};
         gnt_now     = 1'b0;
         if (phase == 0 && dmem_req) begin
            if (req_seen == gw) begin
               dmem_gnt = 1'b1;
               gnt_now  = 1'b1;
               phase    = ld ? 1 : 2;
            end else begin
               dmem_rvalid = noise;
            end
            req_seen++;
         end else if (phase == 1) begin
            if (wait_seen == rw) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = rdv;
               phase       = 2;
            end else begin
               dmem_gnt = noise;
            end
            wait_seen++;
         end else begin
            dmem_gnt = noise;
         end
         @(negedge sys_clk);
         if (dmem_req) o.req_total = o.req_total + 1;
         if (gnt_now) begin
            o.granted = 1'b1;
            o.g_addr  = dmem_addr;
            o.g_wdata = dmem_wdata;
            o.g_wmask = dmem_wmask;
            o.g_we    = dmem_we;
         end
         if (!mem_stall) begin
            done       = 1'b1;
            o.wb_data  = mem_wbpr_write_back_data;
            o.wb_addr  = mem_wbpr_write_back_addr;
            o.wb_wrf   = mempr_wbpr_is_write_rf;
            o.wb_stall = mempr_wbpr_stall;
            o.misal    = mem_misalign;
            o.pc       = mempr_wbpr_now_pc;
            o.instr    = mempr_wbpr_instruction;
         end else begin
            o.stalls = o.stalls + 1;
         end
         @(posedge sys_clk);
         #1;
      end
      o.timeout       = ~done;
      dmem_gnt        = 1'b0;
      dmem_rvalid     = 1'b0;
      mempr_mem_valid = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      mempr_mem_valid = 1'b1;
      mempr_mem_is_load = 1'b1;
      mempr_mem_is_write_rf = 1'b1;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      n_vec++;
      if ({dmem_req, mem_stall, mem_misalign, mempr_wbpr_stall, mempr_wbpr_is_write_rf} !== 5'b00010) begin
         n_err++;
         $display("FAIL reset_outputs: got req/stall/mis/bub/wrf=%b expected 00010",
                  {dmem_req, mem_stall, mem_misalign, mempr_wbpr_stall, mempr_wbpr_is_write_rf});
      end
      @(posedge sys_clk);
      #1;
      mempr_mem_valid = 1'b0;
      mempr_mem_is_load = 1'b0;
      sys_rst = 1'b1;
   endtask

   task automatic test_alu_pass();
      obs_t o;
      do_op(1'b0, 1'b0, 1'b0, 2'b11, 64'h1234, 64'd0, 64'd0, 0, 0, 1'b1, 5'd7, 1'b1, o);
      n_vec++;
      if (o.timeout || o.stalls != 0 || o.wb_data !== 64'h1234 || o.wb_wrf !== 1'b1) begin
         n_err++;
         $display("FAIL alu_pass: got stalls=%0d data=%h wrf=%b to=%b expected 0 1234 1 0",
                  o.stalls, o.wb_data, o.wb_wrf, o.timeout);
      end
      n_vec++;
      if (o.wb_addr !== 5'd7 || o.pc !== mempr_mem_now_pc || o.instr !== mempr_mem_instruction
          || o.wb_stall !== 1'b0) begin
         n_err++;
         $display("FAIL alu_passthru: got rd=%0d pc=%h ins=%h bub=%b expected 7 %h %h 0",
                  o.wb_addr, o.pc, o.instr, o.wb_stall, mempr_mem_now_pc, mempr_mem_instruction);
      end
   endtask

   task automatic test_lb();
      obs_t o;
      do_op(1'b1, 1'b0, 1'b0, 2'b00, 64'h1003, 64'd0, 64'h00000000_80000000, 0, 0,
            1'b1, 5'd3, 1'b1, o);
      n_vec++;
      if (o.timeout || o.stalls != 3 || o.wb_data !== 64'hFFFFFFFF_FFFFFF80 || o.wb_wrf !== 1'b1) begin
         n_err++;
         $display("FAIL lb: got stalls=%0d data=%h wrf=%b expected 3 ffffffffffffff80 1",
                  o.stalls, o.wb_data, o.wb_wrf);
      end
      n_vec++;
      if (o.g_addr !== 64'h1000 || o.g_we !== 1'b0 || o.g_wmask !== 8'h08) begin
         n_err++;
         $display("FAIL lb_bus: got addr=%h we=%b mask=%h expected 1000 0 08",
                  o.g_addr, o.g_we, o.g_wmask);
      end
   endtask

   task automatic test_sh();
      obs_t o;
      do_op(1'b0, 1'b1, 1'b0, 2'b01, 64'h2002, 64'hBEEF, 64'd0, 2, 0, 1'b1, 5'd9, 1'b1, o);
      n_vec++;
      if (o.timeout || o.stalls != 4 || o.wb_wrf !== 1'b0) begin
         n_err++;
         $display("FAIL sh_timing: got stalls=%0d wrf=%b expected 4 0", o.stalls, o.wb_wrf);
      end
      n_vec++;
      if (o.g_wdata !== 64'h00000000_BEEF0000 || o.g_wmask !== 8'h0C || o.g_we !== 1'b1
          || o.g_addr !== 64'h2000) begin
         n_err++;
         $display("FAIL sh_bus: got wdata=%h mask=%h we=%b addr=%h expected beef0000 0c 1 2000",
                  o.g_wdata, o.g_wmask, o.g_we, o.g_addr);
      end
   endtask

   task automatic test_reset_in_wait();
      obs_t o;
      int   n;
      mempr_mem_valid      = 1'b1;
      mempr_mem_is_load    = 1'b1;
      mempr_mem_is_store   = 1'b0;
      mempr_mem_size       = 2'b10;
      mempr_mem_alu_result = 64'h1000;
      n = 0;
      while (!dmem_req && n < 10) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      n_vec++;
      if (!dmem_req) begin
         n_err++;
         $display("FAIL lw_req_timeout: got req=%b expected 1", dmem_req);
      end
      dmem_gnt = 1'b1;
      @(posedge sys_clk);
      #1;
      dmem_gnt = 1'b0;
      @(negedge sys_clk);
      n_vec++;
      if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL lw_wait: got stall=%b req=%b expected 1 0", mem_stall, dmem_req);
      end
      sys_rst = 1'b0;
      #1;
      n_vec++;
      if ({dmem_req, mem_stall, mempr_wbpr_stall, mempr_wbpr_is_write_rf} !== 4'b0010) begin
         n_err++;
         $display("FAIL rst_in_wait: got req/stall/bub/wrf=%b expected 0010",
                  {dmem_req, mem_stall, mempr_wbpr_stall, mempr_wbpr_is_write_rf});
      end
      @(posedge sys_clk);
      #1;
      sys_rst         = 1'b1;
      mempr_mem_valid = 1'b0;
      dmem_rvalid     = 1'b1;
      dmem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge sys_clk);
      n_vec++;
      if ({dmem_req, mem_stall, mempr_wbpr_stall} !== 3'b001) begin
         n_err++;
         $display("FAIL late_rvalid: got req/stall/bub=%b expected 001",
                  {dmem_req, mem_stall, mempr_wbpr_stall});
      end
      @(posedge sys_clk);
      #1;
      dmem_rvalid = 1'b0;
      do_op(1'b0, 1'b0, 1'b0, 2'b11, 64'h55, 64'd0, 64'd0, 0, 0, 1'b1, 5'd1, 1'b0, o);
      n_vec++;
      if (o.timeout || o.stalls != 0 || o.wb_data !== 64'h55) begin
         n_err++;
         $display("FAIL post_rst_idle: got stalls=%0d data=%h expected 0 55", o.stalls, o.wb_data);
      end
      do_op(1'b1, 1'b0, 1'b1, 2'b10, 64'h1000, 64'd0, 64'h12345678_9ABCDEF0, 1, 1,
            1'b1, 5'd2, 1'b0, o);
      n_vec++;
      if (o.timeout || o.stalls != 5 || o.wb_data !== 64'h00000000_9ABCDEF0) begin
         n_err++;
         $display("FAIL post_rst_lw: got stalls=%0d data=%h expected 5 000000009abcdef0",
                  o.stalls, o.wb_data);
      end
   endtask

   task automatic test_misalign();
      obs_t o;
      do_op(1'b1, 1'b0, 1'b0, 2'b11, 64'h1004, 64'd0, 64'h11223344_55667788, 0, 0,
            1'b1, 5'd4, 1'b0, o);
`ifdef YSYX_22040383_MISALIGN_CHK_EN
      n_vec++;
      if (o.timeout || o.misal !== 1'b1 || o.req_total != 0 || o.stalls != 0
          || o.wb_stall !== 1'b1 || o.wb_wrf !== 1'b0) begin
         n_err++;
         $display("FAIL ld_misalign: got mis=%b reqs=%0d stalls=%0d bub=%b wrf=%b expected 1 0 0 1 0",
                  o.misal, o.req_total, o.stalls, o.wb_stall, o.wb_wrf);
      end
`else
      n_vec++;
      if (o.timeout || o.misal !== 1'b0 || o.g_wmask !== 8'hF0 || o.stalls != 3
          || o.wb_data !== 64'h00000000_11223344) begin
         n_err++;
         $display("FAIL ld_unaligned: got mis=%b mask=%h stalls=%0d data=%h expected 0 f0 3 11223344",
                  o.misal, o.g_wmask, o.stalls, o.wb_data);
      end
`endif
   endtask

   task automatic test_invalid();
      mempr_mem_valid       = 1'b0;
      mempr_mem_is_load     = 1'b1;
      mempr_mem_is_write_rf = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         n_vec++;
         if ({dmem_req, mem_stall, mempr_wbpr_stall, mempr_wbpr_is_write_rf} !== 4'b0010) begin
            n_err++;
            $display("FAIL invalid_ld: got req/stall/bub/wrf=%b expected 0010",
                     {dmem_req, mem_stall, mempr_wbpr_stall, mempr_wbpr_is_write_rf});
         end
      end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_random();
      obs_t        o;
      int          sel, off, nb, gw, rw, exp_st;
      logic        ld, st, uns, wrf, mem, mis, is_st;
      logic [1:0]  sz;
      logic [63:0] alu, sd, rdv;
      for (int k = 0; k < 80; k++) begin
         sel = $urandom_range(0, 5);
         ld  = (sel == 2 || sel == 3 || sel == 5);
         st  = (sel == 4 || sel == 5);
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom);
         wrf = 1'($urandom);
         alu = {$urandom, $urandom};
         sd  = {$urandom, $urandom};
         rdv = {$urandom, $urandom};
         gw  = $urandom_range(0, 3);
         rw  = $urandom_range(0, 3);
         off = int'(alu[2:0]);
         nb  = 1 << sz;
         mem = ld | st;
         is_st = st & ~ld;
         mis = exp_misal(mem, off, nb);
         do_op(ld, st, uns, sz, alu, sd, rdv, gw, rw, wrf, 5'($urandom), 1'($urandom), o);
         if (!mem || mis) exp_st = 0;
         else if (ld)     exp_st = 3 + gw + rw;
         else             exp_st = 2 + gw;
         n_vec++;
         if (o.timeout || o.stalls != exp_st || o.misal !== mis) begin
            n_err++;
            $display("FAIL rnd_timing[%0d]: got stalls=%0d mis=%b to=%b expected %0d %b 0",
                     k, o.stalls, o.misal, o.timeout, exp_st, mis);
         end
         n_vec++;
         if (o.wb_wrf !== (wrf & ~is_st & ~mis) || o.wb_stall !== mis || o.wb_addr !== mempr_mem_rd) begin
            n_err++;
            $display("FAIL rnd_wb_ctl[%0d]: got wrf=%b bub=%b rd=%0d expected %b %b %0d",
                     k, o.wb_wrf, o.wb_stall, o.wb_addr, wrf & ~is_st & ~mis, mis, mempr_mem_rd);
         end
         n_vec++;
         if (ld && !mis) begin
            if (o.wb_data !== exp_load(rdv, off, nb, uns)) begin
               n_err++;
               $display("FAIL rnd_load[%0d]: got %h expected %h (sz=%0d off=%0d uns=%b)",
                        k, o.wb_data, exp_load(rdv, off, nb, uns), sz, off, uns);
            end
         end else if (!mis) begin
            if (o.wb_data !== alu) begin
               n_err++;
               $display("FAIL rnd_alu[%0d]: got %h expected %h", k, o.wb_data, alu);
            end
         end else if (o.req_total != 0) begin
            n_err++;
            $display("FAIL rnd_mis_req[%0d]: got %0d requests expected 0", k, o.req_total);
         end
         if (mem && !mis) begin
            n_vec++;
            if (o.g_addr !== {alu[63:3], 3'b000} || o.g_we !== is_st
                || o.g_wmask !== exp_mask(off, nb) || o.g_wdata !== exp_wdata(sd, off)) begin
               n_err++;
               $display("FAIL rnd_bus[%0d]: got addr=%h we=%b mask=%h wdata=%h expected %h %b %h %h",
                        k, o.g_addr, o.g_we, o.g_wmask, o.g_wdata, {alu[63:3], 3'b000}, is_st,
                        exp_mask(off, nb), exp_wdata(sd, off));
            end
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      sys_rst               = 1'b0;
      mempr_mem_valid       = 1'b0;
      mempr_mem_now_pc      = 64'd0;
      mempr_mem_instruction = 32'd0;
      mempr_mem_alu_result  = 64'd0;
      mempr_mem_store_data  = 64'd0;
      mempr_mem_is_load     = 1'b0;
      mempr_mem_is_store    = 1'b0;
      mempr_mem_unsigned    = 1'b0;
      mempr_mem_size        = 2'b00;
      mempr_mem_rd          = 5'd0;
      mempr_mem_is_write_rf = 1'b0;
      dmem_gnt              = 1'b0;
      dmem_rvalid           = 1'b0;
      dmem_rdata            = 64'd0;
      test_reset();
      test_alu_pass();
      test_lb();
      test_sh();
      test_reset_in_wait();
      test_misalign();
      test_invalid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_22040383_mem_stage.md
YSYX_22040383_MEM_STAGE -- requirements
Module: ysyx_22040383_mem_stage

Interface
REQ-001 SHALL have port sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port sys_rst  in  1  synchronous, active-low reset.
REQ-003 SHALL have port mempr_mem_valid  in  1  upstream instruction present.
REQ-004 SHALL have ports mempr_mem_now_pc  in  64 and mempr_mem_instruction  in  32  carried through unchanged.
REQ-005 SHALL have port mempr_mem_alu_result  in  64  effective address for a load or store, otherwise the write-back value.
REQ-006 SHALL have port mempr_mem_store_data  in  64  store source, taken from the low bytes.
REQ-007 SHALL have ports mempr_mem_is_load, mempr_mem_is_store, mempr_mem_unsigned  in  1 each, and mempr_mem_size  in  2  (00 B, 01 H, 10 W, 11 D).
REQ-008 SHALL have ports mempr_mem_rd  in  5 and mempr_mem_is_write_rf  in  1.
REQ-009 SHALL have data-memory ports dmem_req, dmem_we  out  1; dmem_addr  out  64; dmem_wdata  out  64; dmem_wmask  out  8; dmem_gnt, dmem_rvalid  in  1; dmem_rdata  in  64.
REQ-010 SHALL have outputs mem_wbpr_write_back_data  out  64 and mem_wbpr_write_back_addr  out  5.
REQ-011 SHALL have outputs mempr_wbpr_now_pc  out  64, mempr_wbpr_instruction  out  32, mempr_wbpr_is_write_rf  out  1 and mempr_wbpr_stall  out  1 (bubble marker).
REQ-012 SHALL have outputs mem_stall  out  1 (freezes upstream) and mem_misalign  out  1.

Function
REQ-013 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-014 Non-memory valid instruction in IDLE SHALL pass combinationally: mem_stall=0; write_back_data=alu_result; zero added latency.
REQ-015 Valid load or store in IDLE SHALL assert mem_stall=1 and go to REQ.
REQ-016 In REQ, dmem_req=1 and dmem_we=is_store; on dmem_gnt, a store goes to DONE and a load goes to WAIT; without gnt it stays in REQ.
REQ-017 In WAIT, on dmem_rvalid, dmem_rdata SHALL be captured into an internal register and the FSM SHALL go to DONE.
REQ-018 dmem_rvalid outside WAIT and dmem_gnt outside REQ SHALL be ignored.
REQ-019 mem_stall SHALL be 1 in REQ and WAIT and in IDLE with a pending memory op; it SHALL be 0 in DONE, where results are presented; DONE SHALL return to IDLE next cycle.
REQ-020 Upstream SHALL hold inputs stable while mem_stall=1.
REQ-021 dmem_addr SHALL be {alu_result[63:3],3'b000}; lane offset off=alu_result[2:0].
REQ-022 Store: dmem_wdata=store_data<<(8*off); dmem_wmask=(size mask 01/03/0F/FF)<<off, truncated to 8 bits.
REQ-023 Load: result=(captured rdata>>(8*off)), truncated to size, then zero-extended if unsigned else sign-extended to 64.
REQ-024 Store SHALL force mempr_wbpr_is_write_rf=0; write_back_addr=mempr_mem_rd in all cases.
REQ-025 is_load and is_store both set SHALL be treated as a load.
REQ-026 mempr_wbpr_stall SHALL be 1 whenever mempr_mem_valid=0, mem_stall=1, or a misaligned access is flagged; in those cycles is_write_rf=0.
REQ-027 With mempr_mem_valid=0, the FSM SHALL stay in IDLE and dmem_req SHALL be 0.

Reset
REQ-028 On a rising edge with sys_rst=0, the FSM SHALL enter IDLE and the capture register SHALL clear to 0, including mid-REQ or mid-WAIT.
REQ-029 While sys_rst=0: dmem_req=0, mem_stall=0, mem_misalign=0, mempr_wbpr_stall=1, mempr_wbpr_is_write_rf=0; other outputs are don't-care.

Configuration
REQ-030 Macro YSYX_22040383_MISALIGN_CHK_EN defined: an access with off not a multiple of its size SHALL skip the FSM, issue no dmem_req, and assert mem_misalign=1 and mempr_wbpr_stall=1 for that cycle with mem_stall=0.
REQ-031 Macro undefined: mem_misalign is tied 0; misaligned accesses proceed per REQ-022/023, with bytes beyond lane 7 dropped.

Verification
REQ-032 ADD, alu_result=0x1234 -> same cycle: write_back_data=0x1234, mem_stall=0, is_write_rf=1.
REQ-033 LB, addr 0x1003, unsigned=0, gnt immediate, rdata=0x00000000_80000000 next cycle -> 3 stall cycles; data=0xFFFFFFFF_FFFFFF80.
REQ-034 SH, addr 0x2002, store_data=0xBEEF, gnt after 2 waits -> wdata=0x00000000_BEEF0000, wmask=0x0C, 4 stall cycles, is_write_rf=0.
REQ-035 LW, addr 0x1000, reset asserted in WAIT, then late rvalid -> IDLE, rvalid ignored, dmem_req=0.
REQ-036 LD, addr 0x1004, macro defined -> mem_misalign=1, no dmem_req, bubble; macro undefined -> access issued with mask 0xF0 and upper bytes dropped.
REQ-037 mempr_mem_valid=0 with is_load=1 -> dmem_req stays 0 and mempr_wbpr_stall=1.
